// File: rtl/multiply8_signed_structural.sv
// 8x8 signed multiplier: Baugh-Wooley partial products, carry-save array, ripple-carry close.
// Define MULT8_SIGNED_PIPE_EN to register the carry-save vectors before the ripple adder (latency 2).

module ha_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic co
);
  assign s  = a ^ b;
  assign co = a & b;
endmodule

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// Bit 15 sum cell: the carry out of the MSB is discarded modulo 2^16.
module msb_sum_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s
);
  assign s = a ^ b ^ ci;
endmodule

module multiply8_signed_structural (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [7:0]  multiplicand_a,
  input  logic signed [7:0]  multiplier_b,
  input  logic               in_valid,
  output logic signed [15:0] product,
  output logic               out_valid
);

  // Stage p0: partial products and carry-save reduction
  logic [63:0]      pp_p0;
  logic [7:0][15:0] csa_s_p0;
  logic [7:0][15:0] csa_c_p0;

  genvar gi, gj, gr, gk;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_pp_row
      for (gj = 0; gj < 8; gj++) begin : g_pp_col
        if ((gi == 7) != (gj == 7)) begin : g_inv
          assign pp_p0[gi*8+gj] = ~(multiplicand_a[gj] & multiplier_b[gi]);
        end else begin : g_pos
          assign pp_p0[gi*8+gj] = multiplicand_a[gj] & multiplier_b[gi];
        end
      end
    end
  endgenerate

  // Row 0 seeds the sum vector; the Baugh-Wooley constants 2^8 + 2^15 seed the carry vector.
  assign csa_s_p0[0] = {8'h00, pp_p0[7:0]};
  assign csa_c_p0[0] = 16'h8100;

  generate
    for (gr = 1; gr < 8; gr++) begin : g_csa_row
      assign csa_c_p0[gr][0] = 1'b0;
      for (gk = 0; gk < 16; gk++) begin : g_csa_bit
        if (gk == 15) begin : g_msb
          msb_sum_cell u_msb (
            .a  (csa_s_p0[gr-1][15]),
            .b  (csa_c_p0[gr-1][15]),
            .ci (1'b0),
            .s  (csa_s_p0[gr][15])
          );
        end else if ((gk >= gr) && (gk <= gr + 7)) begin : g_fa
          fa_cell u_fa (
            .a  (csa_s_p0[gr-1][gk]),
            .b  (csa_c_p0[gr-1][gk]),
            .ci (pp_p0[gr*8+gk-gr]),
            .s  (csa_s_p0[gr][gk]),
            .co (csa_c_p0[gr][gk+1])
          );
        end else begin : g_ha
          ha_cell u_ha (
            .a  (csa_s_p0[gr-1][gk]),
            .b  (csa_c_p0[gr-1][gk]),
            .s  (csa_s_p0[gr][gk]),
            .co (csa_c_p0[gr][gk+1])
          );
        end
      end
    end
  endgenerate

  logic [15:0] rca_x;
  logic [15:0] rca_y;
  logic        rca_load;

`ifdef MULT8_SIGNED_PIPE_EN
  // Stage p1: registered carry-save vectors
  logic [15:0] csa_s_p1;
  logic [15:0] csa_c_p1;
  logic        vld_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csa_s_p1 <= '0;
      csa_c_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        csa_s_p1 <= csa_s_p0[7];
        csa_c_p1 <= csa_c_p0[7];
      end
    end
  end

  assign rca_x    = csa_s_p1;
  assign rca_y    = csa_c_p1;
  assign rca_load = vld_p1;
`else
  assign rca_x    = csa_s_p0[7];
  assign rca_y    = csa_c_p0[7];
  assign rca_load = in_valid;
`endif

  // Ripple-carry adder closing the carry-save pair
  logic [15:0] rca_sum;
  logic [15:1] rca_c;

  ha_cell u_rca0 (
    .a  (rca_x[0]),
    .b  (rca_y[0]),
    .s  (rca_sum[0]),
    .co (rca_c[1])
  );

  generate
    for (gk = 1; gk < 15; gk++) begin : g_rca
      fa_cell u_fa (
        .a  (rca_x[gk]),
        .b  (rca_y[gk]),
        .ci (rca_c[gk]),
        .s  (rca_sum[gk]),
        .co (rca_c[gk+1])
      );
    end
  endgenerate

  msb_sum_cell u_rca15 (
    .a  (rca_x[15]),
    .b  (rca_y[15]),
    .ci (rca_c[15]),
    .s  (rca_sum[15])
  );

  // Output stage: product holds its last value when nothing new arrives
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      product   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= rca_load;
      if (rca_load) begin
        product <= $signed(rca_sum);
      end
    end
  end

endmodule

// File: tb/tb_multiply8_signed_structural.sv
// Self-checking bench for multiply8_signed_structural (both MULT8_SIGNED_PIPE_EN builds).

module tb_multiply8_signed_structural;

`ifdef MULT8_SIGNED_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        in_valid;
  logic [15:0] product;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  multiply8_signed_structural dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .multiplicand_a (a),
    .multiplier_b   (b),
    .in_valid       (in_valid),
    .product        (product),
    .out_valid      (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] p;
  } ent_t;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  ent_t        dl [0:1];
  logic [15:0] exp_prod;
  logic        exp_vld;
  vec_t        tbl [21];

  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    int p;
    p = int'($signed(x)) * int'($signed(y));
    return p[15:0];
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, advance the reference delay line, compare outputs.
  task automatic cycle(input logic rn, input logic v, input logic [7:0] x, input logic [7:0] y);
    ent_t outgoing;
    rst_n    = rn;
    in_valid = v;
    a        = x;
    b        = y;
    @(posedge clk);
    if (!rn) begin
      for (int k = 0; k < 2; k++) dl[k].v = 1'b0;
      exp_prod = 16'h0000;
      exp_vld  = 1'b0;
    end else begin
      for (int k = LAT - 1; k > 0; k--) dl[k] = dl[k-1];
      dl[0].v  = v;
      dl[0].p  = ref_mul(x, y);
      outgoing = dl[LAT-1];
      exp_vld  = outgoing.v;
      if (outgoing.v) exp_prod = outgoing.p;
    end
    #1;
    check("out_valid", {15'b0, out_valid}, {15'b0, exp_vld});
    check("product", product, exp_prod);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      dl[k].v = 1'b0;
      dl[k].p = 16'h0000;
    end
    exp_prod = 16'h0000;
    exp_vld  = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = 8'h00;
    b        = 8'h00;

    tbl[0]  = '{8'h01, 8'h01, 16'h0001};
    tbl[1]  = '{8'h02, 8'h02, 16'h0004};
    tbl[2]  = '{8'h04, 8'h04, 16'h0010};
    tbl[3]  = '{8'h08, 8'h08, 16'h0040};
    tbl[4]  = '{8'h10, 8'h10, 16'h0100};
    tbl[5]  = '{8'h20, 8'h20, 16'h0400};
    tbl[6]  = '{8'h40, 8'h40, 16'h1000};
    tbl[7]  = '{8'hFF, 8'hFF, 16'h0001};
    tbl[8]  = '{8'hFE, 8'hFE, 16'h0004};
    tbl[9]  = '{8'hFC, 8'hFC, 16'h0010};
    tbl[10] = '{8'hF8, 8'hF8, 16'h0040};
    tbl[11] = '{8'hF0, 8'hF0, 16'h0100};
    tbl[12] = '{8'hE0, 8'hE0, 16'h0400};
    tbl[13] = '{8'hC0, 8'hC0, 16'h1000};
    tbl[14] = '{8'h80, 8'h80, 16'h4000};
    tbl[15] = '{8'h80, 8'h01, 16'hFF80};
    tbl[16] = '{8'h7F, 8'h80, 16'hC080};
    tbl[17] = '{8'h7F, 8'h7F, 16'h3F01};
    tbl[18] = '{8'h00, 8'h80, 16'h0000};
    tbl[19] = '{8'h00, 8'hFF, 16'h0000};
    tbl[20] = '{8'hFF, 8'h00, 16'h0000};

    // Reset held with valid operands present
    repeat (3) cycle(1'b0, 1'b1, 8'h40, 8'h40);
    check("reset_product", product, 16'h0000);
    check("reset_valid", {15'b0, out_valid}, 16'h0000);

    // Directed table
    for (int i = 0; i < 21; i++) begin
      cycle(1'b1, 1'b1, tbl[i].a, tbl[i].b);
      repeat (LAT - 1) cycle(1'b1, 1'b0, 8'h00, 8'h00);
      check("tbl_valid", {15'b0, out_valid}, 16'h0001);
      check("tbl_product", product, tbl[i].exp);
      cycle(1'b1, 1'b0, 8'h55, 8'hAA);
      check("hold_product", product, tbl[i].exp);
      check("hold_valid", {15'b0, out_valid}, 16'h0000);
    end

    // Back-to-back streaming
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, 8'(i * 3 + 1), 8'(8'hF0 + i));
      if (i >= LAT - 1) check("stream_valid", {15'b0, out_valid}, 16'h0001);
    end
    repeat (LAT) cycle(1'b1, 1'b0, 8'h00, 8'h00);

    // Reset pulse mid-stream drops in-flight results
    cycle(1'b1, 1'b1, 8'h11, 8'h22);
    cycle(1'b0, 1'b1, 8'h33, 8'h44);
    check("drop_product", product, 16'h0000);
    for (int i = 0; i < LAT + 1; i++) begin
      cycle(1'b1, 1'b0, 8'h00, 8'h00);
      check("drop_valid", {15'b0, out_valid}, 16'h0000);
    end

    // First operands after reset release are accepted
    cycle(1'b1, 1'b1, 8'h05, 8'h06);
    repeat (LAT - 1) cycle(1'b1, 1'b0, 8'h00, 8'h00);
    check("post_reset_valid", {15'b0, out_valid}, 16'h0001);
    check("post_reset_product", product, 16'h001E);

    // Randomized traffic with sporadic resets
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(63) != 0), ($urandom_range(3) != 0),
            8'($urandom_range(255)), 8'($urandom_range(255)));
    end

    // Exhaustive streaming sweep
    for (int ia = 0; ia < 256; ia++) begin
      for (int ib = 0; ib < 256; ib++) begin
        cycle(1'b1, 1'b1, 8'(ia), 8'(ib));
      end
    end
    repeat (LAT + 1) cycle(1'b1, 1'b0, 8'h00, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiply8_signed_structural.md
MULTIPLY8_SIGNED_STRUCTURAL -- requirements
Module: multiply8_signed_structural

Interface
REQ-001 The block SHALL have no parameters; operand widths are fixed at 8 bits and the product width at 16 bits.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 Ports SHALL be:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- product  output  16  two's-complement product, registered
- multiplicand_a  input  8  two's-complement multiplicand
- multiplier_b  input  8  two's-complement multiplier
- in_valid  input  1  operands valid this cycle
- out_valid  output  1  product valid this cycle

Function
REQ-004 The product SHALL equal signed(multiplicand_a) x signed(multiplier_b), exact in 16 bits, with no overflow for any operand pair (range -16256..+16384).
REQ-005 Arithmetic SHALL be structural: AND-gate partial products, Baugh-Wooley sign handling (inverted MSB-row/column terms plus correction constants), and a carry-save array of explicit half/full-adder instances closed by a ripple-carry adder; no behavioural multiply operator.
REQ-006 Baseline latency SHALL be 1 cycle: operands sampled at edge N with in_valid=1 give product and out_valid=1 after edge N.
REQ-007 out_valid SHALL follow in_valid by exactly the pipeline latency, with one result per cycle for back-to-back valid operands and no stall or backpressure.
REQ-008 When in_valid=0 the product register SHALL hold its last value and out_valid SHALL deassert after the pipeline latency.
REQ-009 Operands SHALL be treated as signed: 0x80 = -128 and 0xFF = -1.
REQ-010 Corner case: -128 x -128 SHALL give 0x4000.
REQ-011 Corner case: a zero operand SHALL give 0x0000 regardless of the other operand's sign.

Reset
REQ-012 While rst_n=0 at a rising clk edge, product SHALL be 0x0000, out_valid SHALL be 0, and all internal pipeline registers SHALL be cleared.
REQ-013 Reset SHALL take priority over in_valid in the same cycle.
REQ-014 A reset asserted mid-operation SHALL discard in-flight results; no out_valid pulse SHALL occur for operands accepted before the reset.
REQ-015 After rst_n returns to 1, the first operands with in_valid=1 SHALL be accepted on the next edge.

Configuration
REQ-016 Macro MULT8_SIGNED_PIPE_EN: when defined, a register stage SHALL be inserted between the carry-save array and the final ripple adder, making latency 2 cycles with out_valid delayed to match.
REQ-017 When MULT8_SIGNED_PIPE_EN is not defined, latency SHALL be 1 cycle.
REQ-018 Function, reset behaviour and throughput SHALL be identical in both builds except for latency.

Verification
REQ-019 Powers of two: a=b=0x01,0x02,0x04,0x08,0x10,0x20,0x40 -> 0x0001,0x0004,0x0010,0x0040,0x0100,0x0400,0x1000 after the latency.
REQ-020 Negative squares: a=b=0xFF,0xFE,0xFC,0xF8,0xF0,0xE0,0xC0,0x80 -> 0x0001,0x0004,0x0010,0x0040,0x0100,0x0400,0x1000,0x4000.
REQ-021 Mixed signs: 0x80x0x01 -> 0xFF80; 0x7Fx0x80 -> 0xC080; 0x7Fx0x7F -> 0x3F01; 0x00x0x80 -> 0x0000.
REQ-022 Streaming: valid operand pairs on consecutive cycles -> matching products on consecutive cycles with out_valid held at 1.
REQ-023 Reset: hold rst_n=0 with in_valid=1 and a=b=0x40 -> product=0x0000 and out_valid=0; pulse rst_n=0 mid-stream -> the in-flight result is dropped.
REQ-024 Both builds: run all scenarios with and without MULT8_SIGNED_PIPE_EN -> latency is 1 vs 2 cycles and all values are identical; an exhaustive 65536-pair sweep is compared against a signed reference model.
